// File: rtl/io_pkg.sv
// io_pkg: shared widths, FIFO depth default and TX state encoding for the I/O port.
package io_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int AC_W_DEF     = 16;
  localparam int RX_DEPTH_DEF = 4;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
endpackage

// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: external RX/TX handshakes and CPU INP/OUT strobes; irq pins exist only with IO_IRQ_EN.
interface io_port_ctrl_if #(parameter int DATA_W = 8, parameter int AC_W = 16);
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              inp_rd;
  logic              out_wr;
  logic [AC_W-1:0]   ac_in;
  logic [DATA_W-1:0] inpr_out;
  logic              fgi;
  logic              fgo;
`ifdef IO_IRQ_EN
  logic              ion;
  logic              iof;
  logic              irq_ack;
  logic              irq;
  modport slave  (input  rx_valid, rx_data, tx_ready, inp_rd, out_wr, ac_in, ion, iof, irq_ack,
                  output rx_ready, tx_valid, tx_data, inpr_out, fgi, fgo, irq);
  modport master (output rx_valid, rx_data, tx_ready, inp_rd, out_wr, ac_in, ion, iof, irq_ack,
                  input  rx_ready, tx_valid, tx_data, inpr_out, fgi, fgo, irq);
`else
  modport slave  (input  rx_valid, rx_data, tx_ready, inp_rd, out_wr, ac_in,
                  output rx_ready, tx_valid, tx_data, inpr_out, fgi, fgo);
  modport master (output rx_valid, rx_data, tx_ready, inp_rd, out_wr, ac_in,
                  input  rx_ready, tx_valid, tx_data, inpr_out, fgi, fgo);
`endif
endinterface

// File: rtl/io_rx_fifo.sv
// io_rx_fifo: RX byte FIFO holding INPR; head reads 0 when empty, ready is the registered not-full flag.
module io_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic [$clog2(RX_DEPTH):0] count,
  output logic                      full,
  output logic                      empty,
  output logic                      ready
);
  localparam int AW = $clog2(RX_DEPTH);
  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic [DATA_W-1:0] mem_d [RX_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              do_push, do_pop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(RX_DEPTH);
  assign count   = cnt_q;
  assign ready   = rdy_q;
  assign head    = empty ? '0 : mem_q[rd_q];
  // ready is low for the whole first cycle out of reset, so it alone gates pushes
  assign do_push = push & rdy_q;
  assign do_pop  = pop & ~empty;
  always_comb begin
    mem_d        = mem_q;
    mem_d[wr_q]  = do_push ? push_data : mem_q[wr_q];
    wr_d         = wr_q + AW'(do_push);
    rd_d         = rd_q + AW'(do_pop);
    cnt_d        = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdy_d        = cnt_d != (AW+1)'(RX_DEPTH);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: INPR/FGI via RX FIFO, OUTR/FGO via TX valid/ready FSM; IO_IRQ_EN adds ien and irq.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AC_W     = AC_W_DEF,
  parameter int RX_DEPTH = RX_DEPTH_DEF
) (
  input logic           clk,
  input logic           rst,
  io_port_ctrl_if.slave bus
);
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                      rx_full, rx_empty, rx_ready;
  logic [DATA_W-1:0]         rx_head;
  tx_state_t                 state_q, state_d;
  logic [DATA_W-1:0]         outr_q, outr_d;
  logic                      txv_q, txv_d, fgo_q, fgo_d;
  logic                      wr_ok, hs;
  logic                      unused_ok;
  io_rx_fifo #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.rx_valid),
    .push_data (bus.rx_data),
    .pop       (bus.inp_rd),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .ready     (rx_ready)
  );
  assign bus.rx_ready = rx_ready;
  assign bus.inpr_out = rx_head;
  assign bus.fgi      = ~rx_empty;
  assign bus.tx_valid = txv_q;
  assign bus.tx_data  = outr_q;
  assign bus.fgo      = fgo_q;
  assign unused_ok    = ^{bus.ac_in[AC_W-1:DATA_W], rx_count, rx_full};
  // OUT is only honoured while idle; the handshake cycle itself still counts as SEND
  assign wr_ok = bus.out_wr & (state_q == TX_IDLE);
  assign hs    = (state_q == TX_SEND) & bus.tx_ready;
  always_comb begin
    state_d = wr_ok ? TX_SEND : hs ? TX_IDLE : state_q;
    outr_d  = wr_ok ? bus.ac_in[DATA_W-1:0] : outr_q;
    txv_d   = wr_ok ? 1'b1 : hs ? 1'b0 : txv_q;
    fgo_d   = wr_ok ? 1'b0 : hs ? 1'b1 : fgo_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      outr_q  <= '0;
      txv_q   <= 1'b0;
      fgo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      outr_q  <= outr_d;
      txv_q   <= txv_d;
      fgo_q   <= fgo_d;
    end
  end
`ifdef IO_IRQ_EN
  logic ien_q, ien_d, irq_q, irq_d;
  // irq follows the updated ien so an acknowledge drops it on the very next cycle
  always_comb begin
    ien_d = (bus.iof | bus.irq_ack) ? 1'b0 : bus.ion ? 1'b1 : ien_q;
    irq_d = ien_d & (~rx_empty | fgo_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end
  assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: table-driven vectors for RX FIFO and TX handshake, plus reset and irq sequences.
module tb_io_port_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  always #5 clk = ~clk;
  io_port_ctrl_if #(.DATA_W(8), .AC_W(16)) bus();
  io_port_ctrl #(.DATA_W(8), .AC_W(16), .RX_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic        ird;
    logic        ow;
    logic [15:0] ac;
    logic        tr;
    logic        e_rdy;
    logic        e_fgi;
    logic [7:0]  e_inpr;
    logic        e_fgo;
    logic        e_txv;
    logic [7:0]  e_txd;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic ird, input logic ow,
                              input logic [15:0] ac, input logic tr, input logic e_rdy, input logic e_fgi,
                              input logic [7:0] e_inpr, input logic e_fgo, input logic e_txv,
                              input logic [7:0] e_txd);
    vec_t r;
    r = '{rv, rd, ird, ow, ac, tr, e_rdy, e_fgi, e_inpr, e_fgo, e_txv, e_txd};
    return r;
  endfunction
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_all(input string t, input logic rdy, input logic fgi, input logic [7:0] inpr,
                         input logic fgo, input logic txv, input logic [7:0] txd);
    chk({t, " rx_ready"}, 16'(bus.rx_ready), 16'(rdy));
    chk({t, " fgi"}, 16'(bus.fgi), 16'(fgi));
    chk({t, " inpr_out"}, 16'(bus.inpr_out), 16'(inpr));
    chk({t, " fgo"}, 16'(bus.fgo), 16'(fgo));
    chk({t, " tx_valid"}, 16'(bus.tx_valid), 16'(txv));
    chk({t, " tx_data"}, 16'(bus.tx_data), 16'(txd));
  endtask
  task automatic drive(input vec_t x);
    bus.rx_valid = x.rv;
    bus.rx_data  = x.rd;
    bus.inp_rd   = x.ird;
    bus.out_wr   = x.ow;
    bus.ac_in    = x.ac;
    bus.tx_ready = x.tr;
  endtask
  task automatic apply(input vec_t x, input string t);
    drive(x);
    @(posedge clk);
    #1;
    chk_all(t, x.e_rdy, x.e_fgi, x.e_inpr, x.e_fgo, x.e_txv, x.e_txd);
  endtask
  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef IO_IRQ_EN
    bus.ion = 0; bus.iof = 0; bus.irq_ack = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 8'h00, 1, 0, 8'h00);
    rst = 0;
    v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h11, 0, 0, 16'h0000, 0, 1, 1, 8'h11, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h22, 0, 0, 16'h0000, 0, 1, 1, 8'h11, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h33, 0, 0, 16'h0000, 0, 1, 1, 8'h11, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h44, 0, 0, 16'h0000, 0, 0, 1, 8'h11, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h55, 0, 0, 16'h0000, 0, 0, 1, 8'h11, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 1, 8'h22, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 1, 8'h33, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 1, 8'h44, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 0, 8'h00));
    v.push_back(mk(1, 8'hA1, 0, 0, 16'h0000, 0, 1, 1, 8'hA1, 1, 0, 8'h00));
    v.push_back(mk(1, 8'hA2, 0, 0, 16'h0000, 0, 1, 1, 8'hA1, 1, 0, 8'h00));
    v.push_back(mk(1, 8'hA3, 0, 0, 16'h0000, 0, 1, 1, 8'hA1, 1, 0, 8'h00));
    v.push_back(mk(1, 8'hA4, 0, 0, 16'h0000, 0, 0, 1, 8'hA1, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h55, 1, 0, 16'h0000, 0, 1, 1, 8'hA2, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h55, 0, 0, 16'h0000, 0, 0, 1, 8'hA2, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 1, 8'hA3, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h66, 1, 0, 16'h0000, 0, 1, 1, 8'hA4, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 1, 8'h55, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 1, 8'h66, 1, 0, 8'h00));
    v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 0, 8'h00));
    v.push_back(mk(1, 8'h77, 0, 1, 16'hABCD, 0, 1, 1, 8'h77, 0, 1, 8'hCD));
    v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 1, 8'h77, 0, 1, 8'hCD));
    v.push_back(mk(0, 8'h00, 0, 1, 16'h1234, 0, 1, 1, 8'h77, 0, 1, 8'hCD));
    v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 1, 8'h77, 0, 1, 8'hCD));
    v.push_back(mk(0, 8'h00, 1, 1, 16'h1234, 1, 1, 0, 8'h00, 1, 0, 8'hCD));
    v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 1, 1, 0, 8'h00, 1, 0, 8'hCD));
    v.push_back(mk(0, 8'h00, 0, 1, 16'h00FF, 1, 1, 0, 8'h00, 0, 1, 8'hFF));
    v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 1, 1, 0, 8'h00, 1, 0, 8'hFF));
    v.push_back(mk(0, 8'h00, 0, 1, 16'h5A5A, 0, 1, 0, 8'h00, 0, 1, 8'h5A));
    v.push_back(mk(1, 8'h99, 0, 1, 16'h1111, 0, 1, 1, 8'h99, 0, 1, 8'h5A));
    for (int i = 0; i < v.size(); i++) apply(v[i], $sformatf("row%0d", i));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1;
    #1;
    chk_all("async_rst", 0, 0, 8'h00, 1, 0, 8'h00);
    @(posedge clk);
    #1;
    rst = 0;
    apply(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 0, 8'h00), "post_rst_empty_pop");
    apply(mk(1, 8'hC3, 0, 0, 16'h0000, 0, 1, 1, 8'hC3, 1, 0, 8'h00), "post_rst_push");
`ifdef IO_IRQ_EN
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("irq_idle", 16'(bus.irq), 16'd0);
    bus.ion = 1; @(posedge clk); #1; bus.ion = 0;
    chk("irq_after_ion", 16'(bus.irq), 16'd1);
    bus.irq_ack = 1; @(posedge clk); #1; bus.irq_ack = 0;
    chk("irq_after_ack", 16'(bus.irq), 16'd0);
    bus.ion = 1; bus.iof = 1; @(posedge clk); #1; bus.ion = 0; bus.iof = 0;
    chk("irq_ion_iof", 16'(bus.irq), 16'd0);
    @(posedge clk); #1;
    chk("irq_ion_iof_hold", 16'(bus.irq), 16'd0);
    bus.ion = 1; @(posedge clk); #1; bus.ion = 0;
    chk("irq_reenable", 16'(bus.irq), 16'd1);
    bus.iof = 1; @(posedge clk); #1; bus.iof = 0;
    chk("irq_after_iof", 16'(bus.irq), 16'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
